// File: rtl/sha3_client_pkg.sv
// Shared types and sizing helpers for the sha3 host-side client.
package sha3_client_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ACK
  } state_t;

  function automatic int words_of(input int total, input int w);
    return total / w;
  endfunction

  // Counter width that stays legal when a buffer holds a single word.
  function automatic int cnt_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/sha3_digest_ser.sv
// Digest holding register that serialises MDLEN bits into W-bit words, MSW first.
module sha3_digest_ser
  import sha3_client_pkg::*;
#(
  parameter int MDLEN = 256,
  parameter int W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [MDLEN-1:0] load_data,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             full
);

  localparam int WORDS_OUT = words_of(MDLEN, W);
  localparam int CW = cnt_w(WORDS_OUT);
  localparam logic [CW-1:0] OCNT_LAST = CW'(WORDS_OUT - 1);

  logic [MDLEN-1:0] dig;
  logic [CW-1:0]    ocnt;
  logic             dig_full;
  logic             beat;

  assign beat = dig_full && out_ready;

  // load is only raised while the buffer is empty, so it never meets a beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig      <= '0;
      ocnt     <= '0;
      dig_full <= 1'b0;
    end else if (load) begin
      dig      <= load_data;
      ocnt     <= '0;
      dig_full <= 1'b1;
    end else if (beat) begin
      dig <= dig << W;
      if (ocnt == OCNT_LAST) begin
        ocnt     <= '0;
        dig_full <= 1'b0;
      end else begin
        ocnt <= ocnt + 1'b1;
      end
    end
  end

  assign out_data  = dig[MDLEN-1 -: W];
  assign out_valid = dig_full;
  assign out_last  = dig_full && (ocnt == OCNT_LAST);
  assign full      = dig_full;

endmodule

// File: rtl/sha3_client.sv
// Host-side initiator for the sha3 core: collects a message, runs the core
// handshake and drains the digest, with message and digest double-buffered.
module sha3_client
  import sha3_client_pkg::*;
#(
  parameter int MDLEN = 256,
  parameter int N     = 128,
  parameter int W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [N-1:0]     core_md_in,
  output logic             core_req_valid,
  input  logic             core_req_ready,
  input  logic [MDLEN-1:0] core_md_out,
  input  logic             core_res_valid,
  output logic             core_res_ready,
  output logic             busy
);

  localparam int WORDS_IN = words_of(N, W);
  localparam int CW_IN = cnt_w(WORDS_IN);
  localparam logic [CW_IN-1:0] WCNT_LAST = CW_IN'(WORDS_IN - 1);

  state_t           state;
  state_t           state_next;
  logic [N-1:0]     msg;
  logic [CW_IN-1:0] wcnt;
  logic             msg_full;
  logic             in_beat;
  logic             dig_load;
  logic             dig_full;

  assign in_ready = !msg_full;
  assign in_beat  = in_valid && !msg_full;
  // Capture happens on the edge that enters S_ACK, so the acknowledge cycle
  // already shows the digest and a free message buffer.
  assign dig_load = (state == S_WAIT) && core_res_valid && !dig_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg      <= '0;
      wcnt     <= '0;
      msg_full <= 1'b0;
    end else if (in_beat) begin
      msg <= (msg << W) | N'(in_data);
      if (wcnt == WCNT_LAST) begin
        wcnt     <= '0;
        msg_full <= 1'b1;
      end else begin
        wcnt <= wcnt + 1'b1;
      end
    end else if (dig_load) begin
      msg_full <= 1'b0;
    end
  end

  assign core_md_in = msg;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (msg_full) state_next = S_REQ;
      S_REQ:   if (core_req_ready) state_next = S_WAIT;
      S_WAIT:  if (core_res_valid && !dig_full) state_next = S_ACK;
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      core_req_valid <= 1'b0;
      core_res_ready <= 1'b0;
    end else begin
      state          <= state_next;
      core_req_valid <= (state_next == S_REQ);
      core_res_ready <= (state_next == S_ACK);
    end
  end

  sha3_digest_ser #(
    .MDLEN(MDLEN),
    .W    (W)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dig_load),
    .load_data(core_md_out),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .full     (dig_full)
  );

  assign busy = (state != S_IDLE) || msg_full || dig_full;

endmodule

// File: tb/tb_sha3_client.sv
// Directed bench for sha3_client with a behavioural core returning {md_in, ~md_in}.
module tb_sha3_client;

  logic         clk;
  logic         rst_n;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [127:0] core_md_in;
  logic         core_req_valid;
  logic         core_req_ready;
  logic [255:0] core_md_out;
  logic         core_res_valid;
  logic         core_res_ready;
  logic         busy;

  sha3_client #(.MDLEN(256), .N(128), .W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .core_md_in    (core_md_in),
    .core_req_valid(core_req_valid),
    .core_req_ready(core_req_ready),
    .core_md_out   (core_md_out),
    .core_res_valid(core_res_valid),
    .core_res_ready(core_res_ready),
    .busy          (busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int ready_mode = 0;
  logic [32:0] exp_q[$];
  logic [32:0] rx_q[$];
  int rq_run = 0, rq_len = 0, rs_run = 0, rs_len = 0;
  int req_cnt = 0, ack_cnt = 0, ack_rx = 0;
  logic ack_in_ready = 1'b0, ack_out_valid = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural core: ready one cycle after seeing valid, result 20 cycles later.
  initial begin : core_model
    int cst;
    int ccnt;
    logic [127:0] cmd;
    cst = 0; ccnt = 0; cmd = '0;
    core_req_ready = 1'b0;
    core_res_valid = 1'b0;
    core_md_out = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        core_req_ready = 1'b0;
        core_res_valid = 1'b0;
        cst = 0;
      end else begin
        case (cst)
          0: if (core_req_valid) cst = 1;
          1: begin core_req_ready = 1'b1; cmd = core_md_in; req_cnt++; cst = 2; end
          2: begin core_req_ready = 1'b0; ccnt = 0; cst = 3; end
          3: begin
            ccnt++;
            if (ccnt == 20) begin
              core_res_valid = 1'b1;
              core_md_out = {cmd, ~cmd};
              cst = 4;
            end
          end
          4: if (core_res_ready) cst = 5;
          default: begin core_res_valid = 1'b0; cst = 0; end
        endcase
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Handshake monitor first, then output collection, in one process.
  always @(negedge clk) begin
    if (core_req_valid) rq_run++;
    else if (rq_run != 0) begin rq_len = rq_run; rq_run = 0; end
    if (core_res_ready) rs_run++;
    else if (rs_run != 0) begin rs_len = rs_run; rs_run = 0; end
    if (core_res_ready) begin
      ack_cnt++;
      ack_in_ready = in_ready;
      ack_out_valid = out_valid;
      ack_rx = rx_q.size();
    end
    if (rst_n && out_valid && out_ready) rx_q.push_back({out_last, out_data});
  end

  task automatic push_exp(input logic [127:0] m);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, m[127-32*i -: 32]});
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), ~m[127-32*i -: 32]});
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd, output bit acc);
    acc = 1'b0;
    in_data = w;
    for (int c = 0; c < 3000 && !acc; c++) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_msg(input logic [127:0] m, input bit rnd);
    bit acc;
    int nacc;
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      send_word(m[127-32*i -: 32], rnd, acc);
      if (acc) nacc++;
    end
    chk("send_beats", 256'(nacc), 256'(4));
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("rx_count_reached", 256'(rx_q.size() >= n), 256'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string tag);
    int n;
    chk({tag, "_nwords"}, 256'(rx_q.size()), 256'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_word%0d", tag, i), 256'(rx_q[i]), 256'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 256'(in_ready), 256'(1));
    chk({tag, "_out_valid"}, 256'(out_valid), 256'(0));
    chk({tag, "_out_last"}, 256'(out_last), 256'(0));
    chk({tag, "_req_valid"}, 256'(core_req_valid), 256'(0));
    chk({tag, "_res_ready"}, 256'(core_res_ready), 256'(0));
    chk({tag, "_busy"}, 256'(busy), 256'(0));
    chk({tag, "_out_data"}, 256'(out_data), 256'(0));
    chk({tag, "_md_in"}, 256'(core_md_in), 256'(0));
  endtask

  initial begin : main
    logic [127:0] ma, mb, m;
    int a0, r0, c, md_changes, ir_high;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed message with hand-computed digest words.
    ready_mode = 1;
    rq_len = 0; rs_len = 0;
    send_msg(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0);
    @(negedge clk);
    chk("t1_md_in", 256'(core_md_in), 256'(128'h00112233_44556677_8899AABB_CCDDEEFF));
    chk("t1_in_ready_full", 256'(in_ready), 256'(0));
    exp_q.push_back({1'b0, 32'h00112233});
    exp_q.push_back({1'b0, 32'h44556677});
    exp_q.push_back({1'b0, 32'h8899AABB});
    exp_q.push_back({1'b0, 32'hCCDDEEFF});
    exp_q.push_back({1'b0, 32'hFFEEDDCC});
    exp_q.push_back({1'b0, 32'hBBAA9988});
    exp_q.push_back({1'b0, 32'h77665544});
    exp_q.push_back({1'b1, 32'h33221100});
    wait_rx(8, 300);
    repeat (2) @(negedge clk);
    chk("t1_req_pulse", 256'(rq_len), 256'(2));
    chk("t1_res_pulse", 256'(rs_len), 256'(1));
    chk("t1_in_ready_at_ack", 256'(ack_in_ready), 256'(1));
    chk("t1_out_valid_at_ack", 256'(ack_out_valid), 256'(1));
    compare_all("t1");
    chk("t1_idle_busy", 256'(busy), 256'(0));

    // Two messages with the output stalled: second result must wait.
    ready_mode = 0;
    @(posedge clk);
    #1;
    a0 = ack_cnt;
    r0 = req_cnt;
    ma = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    mb = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    push_exp(ma);
    push_exp(mb);
    send_msg(ma, 1'b0);
    send_msg(mb, 1'b0);
    repeat (40) @(negedge clk);
    chk("t2_second_req", 256'(req_cnt - r0), 256'(2));
    chk("t2_ack_count_stalled", 256'(ack_cnt - a0), 256'(1));
    chk("t2_res_ready_low", 256'(core_res_ready), 256'(0));
    chk("t2_res_valid_pending", 256'(core_res_valid), 256'(1));
    chk("t2_out_data_held", 256'(out_data), 256'(32'h01234567));
    chk("t2_out_last_held", 256'(out_last), 256'(0));
    chk("t2_in_ready_low", 256'(in_ready), 256'(0));
    ready_mode = 1;
    wait_rx(16, 300);
    chk("t2_ack_count", 256'(ack_cnt - a0), 256'(2));
    chk("t2_ack_after_last", 256'(ack_rx), 256'(8));
    compare_all("t2");

    // Random in_valid / out_ready over 50 messages.
    ready_mode = 2;
    for (int k = 0; k < 50; k++) begin
      m = {$urandom, $urandom, $urandom, $urandom};
      push_exp(m);
      send_msg(m, 1'b1);
    end
    wait_rx(400, 20000);
    compare_all("t3");

    // Reset while the client waits for the core result.
    ready_mode = 1;
    c = req_cnt;
    send_msg(128'hDEADBEEF_00000001_CAFEF00D_12345678, 1'b0);
    for (int k = 0; k < 100 && req_cnt == c; k++) @(negedge clk);
    chk("t4_req_seen", 256'(req_cnt - c), 256'(1));
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("t4_wait_rst");
    @(negedge clk);
    rst_n = 1'b1;
    rx_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    m = 128'h11111111_22222222_33333333_44444444;
    push_exp(m);
    send_msg(m, 1'b0);
    wait_rx(8, 300);
    compare_all("t4a");

    // Reset in the middle of draining a digest.
    ready_mode = 0;
    send_msg(128'h89ABCDEF_01234567_76543210_FEDCBA98, 1'b0);
    for (int k = 0; k < 200 && !out_valid; k++) @(negedge clk);
    chk("t4_drain_valid", 256'(out_valid), 256'(1));
    ready_mode = 1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("t4_drain_rst");
    @(negedge clk);
    rst_n = 1'b1;
    rx_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    m = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    push_exp(m);
    send_msg(m, 1'b0);
    wait_rx(8, 300);
    compare_all("t4b");

    // in_valid held while the message buffer is full.
    m = 128'h13579BDF_2468ACE0_FDB97531_0ECA8642;
    push_exp(m);
    send_msg(m, 1'b0);
    in_data = 32'hDEADBEEF;
    in_valid = 1'b1;
    md_changes = 0;
    ir_high = 0;
    c = 0;
    @(negedge clk);
    while (!core_res_ready && c < 200) begin
      if (core_md_in !== m) md_changes++;
      if (in_ready) ir_high++;
      @(negedge clk);
      c++;
    end
    chk("t5_ack_reached", 256'(core_res_ready), 256'(1));
    chk("t5_md_in_at_ack", 256'(core_md_in), 256'(m));
    chk("t5_md_changes", 256'(md_changes), 256'(0));
    chk("t5_in_ready_high_while_full", 256'(ir_high), 256'(0));
    chk("t5_in_ready_at_ack", 256'(in_ready), 256'(1));
    in_valid = 1'b0;
    wait_rx(8, 300);
    compare_all("t5");
    chk("t5_idle_busy", 256'(busy), 256'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
